// File: rtl/eth_mii_tx_serializer.sv
// eth_mii_tx_serializer: drains one queued packet as a byte-wide MII/GMII TX frame (preamble, SFD, payload, pad, FCS, IPG).
// Define ETH_TX_FCS_GEN_EN to zero-pad short frames and append a generated CRC-32 FCS. DATA_W/8 must be a power of two >= 2.
module eth_mii_tx_serializer #(
    parameter int DATA_W      = 64,
    parameter int LEN_W       = 11,
    parameter int MIN_FRAME_B = 60,
    parameter int MAX_FRAME_B = 1514,
    parameter int PREAMBLE_B  = 7,
    parameter int IPG_B       = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_strb,
    input  logic              pkt_avlb,
    input  logic [LEN_W-1:0]  pkt_lnb,
    output logic              pkt_start,
    output logic              word_rd,
    input  logic              word_val,
    input  logic [DATA_W-1:0] word_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              tx_error,
    output logic              busy,
    output logic              tx_done,
    output logic              drop_err,
    output logic              underrun
);
    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int CNT_W  = LEN_W + 1;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES - 1);
    localparam logic [7:0]        PRE_LAST  = 8'(PREAMBLE_B - 1);
    localparam logic [7:0]        IPG_LAST  = 8'(IPG_B - 1);
`ifdef ETH_TX_FCS_GEN_EN
    localparam logic [CNT_W-1:0]  LEN_LO    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LEN_HI    = CNT_W'(MAX_FRAME_B);
    localparam logic [CNT_W-1:0]  PAD_B     = CNT_W'(MIN_FRAME_B);
`else
    localparam logic [CNT_W-1:0]  LEN_LO    = CNT_W'(MIN_FRAME_B + 4);
    localparam logic [CNT_W-1:0]  LEN_HI    = CNT_W'(MAX_FRAME_B + 4);
`endif

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IPG, DRAIN} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  len_q, byte_idx, words_left;
    logic [LANE_W-1:0] lane;
    logic [7:0]        cnt;
    logic [1:0]        out_cnt, stored;
    logic              wr_ptr, rd_ptr, drop_q, good_q;
    logic [DATA_W-1:0] buf_q [2];

    logic [CNT_W-1:0]  l_ext, nwords;
    logic              len_bad, buf_empty, lane_last, data_last, push, pop, fetch;
    logic [7:0]        cur_byte;

    assign l_ext     = {1'b0, pkt_lnb};
    assign nwords    = (l_ext + CNT_W'(BYTES - 1)) >> LANE_W;
    assign len_bad   = (l_ext < LEN_LO) || (l_ext > LEN_HI);
    assign buf_empty = (stored == 2'd0);
    assign lane_last = (lane == LANE_LAST);
    assign data_last = (byte_idx == len_q - 1'b1);
    assign cur_byte  = buf_q[rd_ptr][{lane, 3'b000} +: 8];
    assign busy      = (state != IDLE);

    // Requests are capped by free buffer slots during a frame; while draining only by the outstanding limit.
    assign fetch   = (state == PRE || state == SFD || state == DATA) && (words_left != '0) &&
                     (({1'b0, out_cnt} + {1'b0, stored}) < 3'd2);
    assign word_rd = fetch || ((state == DRAIN) && (words_left != '0) && (out_cnt < 2'd2));
    assign push    = word_val && (state != DRAIN);
    assign pop     = (state == DATA) && byte_strb && !buf_empty && (lane_last || data_last);

`ifdef ETH_TX_FCS_GEN_EN
    logic [31:0] crc;
    logic [31:0] fcs;
    assign fcs = ~crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (pkt_avlb) state_nx = len_bad ? DRAIN : PRE;
            PRE:   if (byte_strb && cnt == PRE_LAST) state_nx = SFD;
            SFD:   if (byte_strb) state_nx = DATA;
            DATA:  if (byte_strb) begin
                       if (buf_empty) state_nx = DRAIN;
`ifdef ETH_TX_FCS_GEN_EN
                       else if (data_last) state_nx = (len_q < PAD_B) ? PAD : FCS;
`else
                       else if (data_last) state_nx = IPG;
`endif
                   end
`ifdef ETH_TX_FCS_GEN_EN
            PAD:   if (byte_strb && byte_idx == PAD_B - 1'b1) state_nx = FCS;
            FCS:   if (byte_strb && cnt == 8'd3) state_nx = IPG;
`endif
            IPG:   if (byte_strb && cnt == IPG_LAST) state_nx = IDLE;
            DRAIN: if (words_left == '0 && out_cnt == 2'd0) state_nx = drop_q ? IDLE : IPG;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr] <= word_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            byte_idx   <= '0;
            words_left <= '0;
            lane       <= '0;
            cnt        <= '0;
            out_cnt    <= '0;
            stored     <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            drop_q     <= 1'b0;
            good_q     <= 1'b0;
            pkt_start  <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            tx_error   <= 1'b0;
            tx_done    <= 1'b0;
            drop_err   <= 1'b0;
            underrun   <= 1'b0;
`ifdef ETH_TX_FCS_GEN_EN
            crc        <= '0;
`endif
        end else begin
            state     <= state_nx;
            pkt_start <= 1'b0;
            tx_done   <= 1'b0;
            drop_err  <= 1'b0;
            underrun  <= 1'b0;
            case ({word_rd, word_val})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: ;
            endcase
            case ({push, pop})
                2'b10:   stored <= stored + 1'b1;
                2'b01:   stored <= stored - 1'b1;
                default: ;
            endcase
            if (word_rd) words_left <= words_left - 1'b1;
            if (push)    wr_ptr <= ~wr_ptr;
            if (pop)     rd_ptr <= ~rd_ptr;

            case (state)
                IDLE: if (pkt_avlb) begin
                    pkt_start  <= 1'b1;
                    len_q      <= l_ext;
                    words_left <= nwords;
                    byte_idx   <= '0;
                    lane       <= '0;
                    drop_q     <= len_bad;
                    drop_err   <= len_bad;
                    good_q     <= 1'b1;
                    stored     <= '0;
                    wr_ptr     <= 1'b0;
                    rd_ptr     <= 1'b0;
                end
                PRE: if (byte_strb) begin
                    tx_data  <= 8'h55;
                    tx_valid <= 1'b1;
                    tx_error <= 1'b0;
                    cnt      <= cnt + 1'b1;
                end
                SFD: if (byte_strb) begin
                    tx_data <= 8'hD5;
`ifdef ETH_TX_FCS_GEN_EN
                    crc     <= 32'hFFFFFFFF;
`endif
                end
                DATA: if (byte_strb) begin
                    if (buf_empty) begin
                        // Missing word: flag one bad byte and abandon the rest of the frame.
                        tx_data  <= 8'h00;
                        tx_error <= 1'b1;
                        underrun <= 1'b1;
                        good_q   <= 1'b0;
                        drop_q   <= 1'b0;
                        stored   <= '0;
                    end else begin
                        tx_data  <= cur_byte;
                        byte_idx <= byte_idx + 1'b1;
                        lane     <= lane_last ? '0 : lane + 1'b1;
`ifdef ETH_TX_FCS_GEN_EN
                        crc      <= crc_byte(crc, cur_byte);
`endif
                    end
                end
`ifdef ETH_TX_FCS_GEN_EN
                PAD: if (byte_strb) begin
                    tx_data  <= 8'h00;
                    byte_idx <= byte_idx + 1'b1;
                    crc      <= crc_byte(crc, 8'h00);
                end
                FCS: if (byte_strb) begin
                    tx_data <= fcs[{cnt[1:0], 3'b000} +: 8];
                    cnt     <= cnt + 1'b1;
                end
`endif
                IPG: if (byte_strb) begin
                    tx_data  <= 8'h00;
                    tx_valid <= 1'b0;
                    tx_error <= 1'b0;
                    tx_done  <= good_q && (cnt == 8'd0);
                    cnt      <= cnt + 1'b1;
                end
                DRAIN: if (byte_strb) begin
                    tx_data  <= 8'h00;
                    tx_valid <= 1'b0;
                    tx_error <= 1'b0;
                end
                default: ;
            endcase
            if (state_nx != state) cnt <= '0;
        end
    end
endmodule
